leaf_switch_allocator: RTL

//  Per-output packet arbiter/sequencer for the leaf router crossbar. Each input (GPU, Spine1-4) presents
//  a packet whose output code comes from the leaf routing table; block grants each output to one input
//  per packet (round-robin, wormhole lock until last flit), drives crossbar selects and ready/valid, drops

---
 rtl/leaf_switch_allocator_if.sv | 24 ++
 rtl/leaf_switch_allocator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/leaf_switch_allocator_if.sv
// Ready/valid bundle between the leaf router ports and the switch allocator.
interface leaf_switch_allocator_if #(
    parameter int NP = 5
);
    logic [NP-1:0]    in_valid;
    logic [3*NP-1:0]  in_dest;
    logic [NP-1:0]    in_last;
    logic [NP-1:0]    in_ready;
    logic [NP-1:0]    out_ready;
    logic [NP-1:0]    out_valid;
    logic [NP*NP-1:0] out_sel;
    logic [NP-1:0]    drop_pulse;
    logic [NP-1:0]    timeout_err;

    modport master (
        output in_valid, in_dest, in_last, out_ready,
        input  in_ready, out_valid, out_sel, drop_pulse, timeout_err
    );

    modport slave (
        input  in_valid, in_dest, in_last, out_ready,
        output in_ready, out_valid, out_sel, drop_pulse, timeout_err
    );
endinterface

// File: rtl/leaf_switch_allocator.sv
// Per-output wormhole allocator for the leaf crossbar: round-robin grant, lock until last flit,
// illegal-route discard and owner-stall watchdog. Per output FSM:
//   state    | meaning
//   S_IDLE   | no owner; arbitrate among legal requesters starting at rr pointer
//   S_LOCKED | owner input streams flits until last transfer or watchdog release
module leaf_switch_allocator #(
    parameter int NP      = 5,
    parameter int TIMEOUT = 16,
    parameter int TW      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    leaf_switch_allocator_if.slave bus
);
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t           state_q [NP];
    state_t           state_d [NP];
    logic [IW-1:0]    owner_q [NP];
    logic [IW-1:0]    owner_d [NP];
    logic [IW-1:0]    rr_q    [NP];
    logic [IW-1:0]    rr_d    [NP];
    logic [TW-1:0]    wd_q    [NP];
    logic [TW-1:0]    wd_d    [NP];
    logic [IW-1:0]    target  [NP];
    logic [NP-1:0]    legal;
    logic [NP-1:0]    owned;
    logic [NP-1:0]    ready_c;
    logic [NP-1:0]    valid_c;
    logic [NP-1:0]    drop_q, drop_d;
    logic [NP-1:0]    tmo_q, tmo_d;
    logic [NP*NP-1:0] sel_c;

    always_comb begin
        logic [2:0] code;
        code  = '0;
        legal = '0;
        for (int i = 0; i < NP; i++) begin
            code      = bus.in_dest[3*i +: 3];
            legal[i]  = (code != 3'd0) && (int'(code) <= NP) && (int'(code) != i + 1);
            target[i] = IW'(code - 3'd1);
        end
    end

    // An input is owned when some locked output currently points at it.
    always_comb begin
        owned = '0;
        sel_c = '0;
        for (int j = 0; j < NP; j++) begin
            if (state_q[j] == S_LOCKED) begin
                owned[owner_q[j]]                    = 1'b1;
                sel_c[NP*j + int'(owner_q[j])]       = 1'b1;
            end
        end
    end

    always_comb begin
        logic [NP-1:0] req;
        logic          found;
        logic [IW-1:0] pick;
        logic [IW-1:0] own;
        int            idx;
        req     = '0;
        found   = 1'b0;
        pick    = '0;
        own     = '0;
        idx     = 0;
        ready_c = '0;
        valid_c = '0;
        drop_d  = '0;
        tmo_d   = '0;
        for (int j = 0; j < NP; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            rr_d[j]    = rr_q[j];
            wd_d[j]    = wd_q[j];
        end

        for (int i = 0; i < NP; i++) begin
            if (!owned[i] && !legal[i]) begin
                ready_c[i] = bus.in_valid[i];
                drop_d[i]  = bus.in_valid[i] & bus.in_last[i];
            end
        end

        for (int j = 0; j < NP; j++) begin
            own = owner_q[j];
            case (state_q[j])
                S_IDLE: begin
                    for (int i = 0; i < NP; i++) begin
                        req[i] = bus.in_valid[i] && legal[i] && !owned[i] && (target[i] == IW'(j));
                    end
                    found = 1'b0;
                    pick  = '0;
                    for (int off = 0; off < NP; off++) begin
                        idx = int'(rr_q[j]) + off;
                        if (idx >= NP) idx = idx - NP;
                        if (!found && req[idx]) begin
                            found = 1'b1;
                            pick  = IW'(idx);
                        end
                    end
                    if (found) begin
                        state_d[j] = S_LOCKED;
                        owner_d[j] = pick;
                        rr_d[j]    = (int'(pick) == NP - 1) ? '0 : pick + 1'b1;
                        wd_d[j]    = '0;
                    end
                end
                S_LOCKED: begin
                    valid_c[j]   = bus.in_valid[own];
                    ready_c[own] = bus.out_ready[j];
                    // Completion is checked first so a finishing packet never reports a timeout.
                    if (bus.in_valid[own] && bus.out_ready[j] && bus.in_last[own]) begin
                        state_d[j] = S_IDLE;
                        owner_d[j] = '0;
                        wd_d[j]    = '0;
                    end else if (bus.in_valid[own]) begin
                        wd_d[j] = '0;
                    end else if (TIMEOUT != 0) begin
                        if (int'(wd_q[j]) + 1 >= TIMEOUT) begin
                            state_d[j] = S_IDLE;
                            owner_d[j] = '0;
                            wd_d[j]    = '0;
                            tmo_d[j]   = 1'b1;
                        end else begin
                            wd_d[j] = wd_q[j] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[j] = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NP; j++) begin
                state_q[j] <= S_IDLE;
                owner_q[j] <= '0;
                rr_q[j]    <= '0;
                wd_q[j]    <= '0;
            end
            drop_q <= '0;
            tmo_q  <= '0;
        end else begin
            for (int j = 0; j < NP; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                rr_q[j]    <= rr_d[j];
                wd_q[j]    <= wd_d[j];
            end
            drop_q <= drop_d;
            tmo_q  <= tmo_d;
        end
    end

    assign bus.in_ready    = rst ? '0 : ready_c;
    assign bus.out_valid   = rst ? '0 : valid_c;
    assign bus.out_sel     = sel_c;
    assign bus.drop_pulse  = drop_q;
    assign bus.timeout_err = tmo_q;
endmodule
